// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock-enable divider family.
package clk_div_pkg;

  // Output mode encodings: square wave of period 2N, or one-cycle pulse every N.
  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // Reset defaults shared by every timebase stage (replaces the fixed divide-by-5).
  localparam int   DEFAULT_DIV_VALUE = 5;
  localparam logic DEFAULT_DIV_MODE  = MODE_TOGGLE;

endpackage

// File: rtl/div_load_shadow.sv
// Shadow register for divisor reloads: captures a request, holds it pending
// until the counter applies it, and acknowledges with a one-cycle pulse.
module div_load_shadow
  import clk_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic [WIDTH-1:0] div_value,
  input  logic             div_mode,
  input  logic             div_load,
  input  logic             apply,
  output logic             pend,
  output logic [WIDTH-1:0] pend_div,
  output logic             pend_mode,
  output logic             ack
);

  logic capture;

  // A new request is only taken when nothing is pending and we are not in the
  // ack cycle, so a requester still holding div_load during ack is not re-captured.
  assign capture = div_load && !pend && !ack;

  // Capture/apply bookkeeping; apply clears pend and raises ack for one cycle.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      pend      <= 1'b0;
      ack       <= 1'b0;
      pend_div  <= WIDTH'(1);
      pend_mode <= MODE_TOGGLE;
    end else begin
      ack <= apply && pend;
      if (apply && pend) begin
        pend <= 1'b0;
      end else if (capture) begin
        pend      <= 1'b1;
        pend_div  <= (div_value == '0) ? WIDTH'(1) : div_value;
        pend_mode <= div_mode;
      end
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock-enable divider: counts clock_in ticks and emits either a
// divide-by-2N square wave or a one-cycle pulse every N cycles.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int   WIDTH        = 8,
  parameter int   DEFAULT_DIV  = DEFAULT_DIV_VALUE,
  parameter logic DEFAULT_MODE = DEFAULT_DIV_MODE
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_value,
  input  logic             div_mode,
  input  logic             div_load,
  output logic             div_ack,
  output logic             clock_out,
  output logic             tick,
  output logic [WIDTH-1:0] timer_cnt
);

  logic [WIDTH-1:0] act_div;
  logic             act_mode;
  logic             pend;
  logic [WIDTH-1:0] pend_div;
  logic             pend_mode;
  logic             terminal;
  logic             apply;

  // act_div is never 0, so the subtraction cannot underflow; >= tolerates a
  // count left above the new limit.
  assign terminal = (timer_cnt >= (act_div - WIDTH'(1)));

  // A pending divisor lands at the next wrap while running, or at once when idle.
  assign apply = pend && (!enable || terminal);

  div_load_shadow #(
    .WIDTH(WIDTH)
  ) u_shadow (
    .clock_in  (clock_in),
    .reset     (reset),
    .div_value (div_value),
    .div_mode  (div_mode),
    .div_load  (div_load),
    .apply     (apply),
    .pend      (pend),
    .pend_div  (pend_div),
    .pend_mode (pend_mode),
    .ack       (div_ack)
  );

  // Counter, outputs and active divisor; outputs in a wrap cycle follow the old mode.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      timer_cnt <= '0;
      clock_out <= 1'b0;
      tick      <= 1'b0;
      act_div   <= WIDTH'(DEFAULT_DIV);
      act_mode  <= DEFAULT_MODE;
    end else if (enable) begin
      if (terminal) begin
        timer_cnt <= '0;
        tick      <= 1'b1;
        clock_out <= (act_mode == MODE_TOGGLE) ? ~clock_out : 1'b1;
        if (pend) begin
          act_div  <= pend_div;
          act_mode <= pend_mode;
        end
      end else begin
        timer_cnt <= timer_cnt + WIDTH'(1);
        tick      <= 1'b0;
        clock_out <= (act_mode == MODE_TOGGLE) ? clock_out : 1'b0;
      end
    end else begin
      tick <= 1'b0;
      if (pend) begin
        act_div   <= pend_div;
        act_mode  <= pend_mode;
        timer_cnt <= '0;
        if (pend_mode == MODE_PULSE) begin
          clock_out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: table of hand-computed per-edge vectors
// followed by hand-written sequences for edge divisors and handshake contention.
module tb_clk_div_prog;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] dv;
    logic       dm;
    logic       ld;
    logic [7:0] cnt;
    logic       tick;
    logic       clk;
    logic       ack;
  } vec_t;

  logic       clock_in;
  logic       reset;
  logic       enable;
  logic [7:0] div_value;
  logic       div_mode;
  logic       div_load;
  logic       div_ack;
  logic       clock_out;
  logic       tick;
  logic [7:0] timer_cnt;

  int checks;
  int failures;
  vec_t vecs[$];

  clk_div_prog #(
    .WIDTH        (8),
    .DEFAULT_DIV  (5),
    .DEFAULT_MODE (1'b0)
  ) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .enable    (enable),
    .div_value (div_value),
    .div_mode  (div_mode),
    .div_load  (div_load),
    .div_ack   (div_ack),
    .clock_out (clock_out),
    .tick      (tick),
    .timer_cnt (timer_cnt)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic addVec(input logic r, input logic e, input logic [7:0] dv, input logic dm,
                        input logic ld, input logic [7:0] c, input logic t, input logic k,
                        input logic a);
    vec_t v;
    v.rst = r; v.en = e; v.dv = dv; v.dm = dm; v.ld = ld;
    v.cnt = c; v.tick = t; v.clk = k; v.ack = a;
    vecs.push_back(v);
  endtask

  // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [7:0] dv,
                               input logic dm, input logic ld);
    @(negedge clock_in);
    reset = r; enable = e; div_value = dv; div_mode = dm; div_load = ld;
    @(posedge clock_in);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] c, input logic t,
                             input logic k, input logic a);
    checks++;
    if (timer_cnt !== c || tick !== t || clock_out !== k || div_ack !== a) begin
      failures++;
      $display("[TB] FAIL %s: got cnt=%0d tick=%b clk=%b ack=%b, want cnt=%0d tick=%b clk=%b ack=%b",
               name, timer_cnt, tick, clock_out, div_ack, c, t, k, a);
    end
  endtask

  task automatic step(input string name, input logic r, input logic e, input logic [7:0] dv,
                      input logic dm, input logic ld, input logic [7:0] c, input logic t,
                      input logic k, input logic a);
    applyStimulus(r, e, dv, dm, ld);
    checkOutput(name, c, t, k, a);
  endtask

  initial begin
    logic       exp_clk;
    logic [7:0] exp_cnt;
    checks = 0; failures = 0;
    reset = 1'b1; enable = 1'b0; div_value = '0; div_mode = 1'b0; div_load = 1'b0;

    // Reset default run, then runtime reload to 3 at count 2
    addVec(1,0,0,0,0, 0,0,0,0);
    addVec(1,0,0,0,0, 0,0,0,0);
    addVec(0,1,0,0,0, 1,0,0,0);
    addVec(0,1,0,0,0, 2,0,0,0);
    addVec(0,1,0,0,0, 3,0,0,0);
    addVec(0,1,0,0,0, 4,0,0,0);
    addVec(0,1,0,0,0, 0,1,1,0);
    addVec(0,1,0,0,0, 1,0,1,0);
    addVec(0,1,0,0,0, 2,0,1,0);
    addVec(0,1,3,0,1, 3,0,1,0);
    addVec(0,1,3,0,1, 4,0,1,0);
    addVec(0,1,3,0,1, 0,1,0,1);
    addVec(0,1,3,0,0, 1,0,0,0);
    addVec(0,1,3,0,0, 2,0,0,0);
    addVec(0,1,3,0,0, 0,1,1,0);
    addVec(0,1,3,0,0, 1,0,1,0);
    addVec(0,1,3,0,0, 2,0,1,0);
    addVec(0,1,3,0,0, 0,1,0,0);
    addVec(0,1,3,0,0, 1,0,0,0);
    addVec(0,1,3,0,0, 2,0,0,0);
    addVec(0,1,3,0,0, 0,1,1,0);
    addVec(0,1,3,0,0, 1,0,1,0);
    // Pulse mode divisor 4 loaded while idle, then an enable gap of 3
    addVec(0,0,4,1,1, 1,0,1,0);
    addVec(0,0,4,1,1, 0,0,0,1);
    addVec(0,0,4,1,0, 0,0,0,0);
    addVec(0,1,4,1,0, 1,0,0,0);
    addVec(0,1,4,1,0, 2,0,0,0);
    addVec(0,1,4,1,0, 3,0,0,0);
    addVec(0,1,4,1,0, 0,1,1,0);
    addVec(0,1,4,1,0, 1,0,0,0);
    addVec(0,1,4,1,0, 2,0,0,0);
    addVec(0,0,4,1,0, 2,0,0,0);
    addVec(0,0,4,1,0, 2,0,0,0);
    addVec(0,0,4,1,0, 2,0,0,0);
    addVec(0,1,4,1,0, 3,0,0,0);
    addVec(0,1,4,1,0, 0,1,1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].en, vecs[i].dv, vecs[i].dm, vecs[i].ld,
           vecs[i].cnt, vecs[i].tick, vecs[i].clk, vecs[i].ack);
    end

    // Divisor 0 behaves as 1: tick every cycle, clock_out at half rate
    step("div0_capture", 0,0,0,0,1, 0,0,1,0);
    step("div0_apply",   0,0,0,0,1, 0,0,1,1);
    exp_clk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_clk = ~exp_clk;
      step($sformatf("div1_run%0d", i), 0,1,0,0,0, 0,1,exp_clk,0);
    end

    // Second load while pending is ignored; load held through ack is not re-captured
    step("hs_reset",   1,0,0,0,0, 0,0,0,0);
    step("hs_cap",     0,1,3,0,1, 1,0,0,0);
    step("hs_ign2",    0,1,7,0,1, 2,0,0,0);
    step("hs_ign3",    0,1,7,0,1, 3,0,0,0);
    step("hs_ign4",    0,1,7,0,1, 4,0,0,0);
    step("hs_ack",     0,1,7,0,1, 0,1,1,1);
    step("hs_heldack", 0,1,7,0,1, 1,0,1,0);
    step("hs_div3_a",  0,1,7,0,0, 2,0,1,0);
    step("hs_div3_b",  0,1,7,0,0, 0,1,0,0);
    step("hs_div3_c",  0,1,7,0,0, 1,0,0,0);
    step("hs_div3_d",  0,1,7,0,0, 2,0,0,0);
    step("hs_div3_e",  0,1,7,0,0, 0,1,1,0);

    // Reset with a pending request drops it: no ack, divisor back to 5
    step("rp_cap",   0,1,2,1,1, 1,0,1,0);
    step("rp_reset", 1,1,2,1,0, 0,0,0,0);
    for (int i = 1; i <= 4; i++) begin
      step($sformatf("rp_run%0d", i), 0,1,2,1,0, 8'(i),0,0,0);
    end
    step("rp_wrap", 0,1,2,1,0, 0,1,1,0);

    // Divisor 255 in pulse mode: full-range count with no overflow
    step("d255_capture", 0,0,255,1,1, 0,0,1,0);
    step("d255_apply",   0,0,255,1,1, 0,0,0,1);
    for (int k = 1; k <= 510; k++) begin
      exp_cnt = 8'(k % 255);
      step($sformatf("d255_e%0d", k), 0,1,255,1,0, exp_cnt,
           (exp_cnt == 0), (exp_cnt == 0), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable, parametrised clock-enable divider for the timebase chain. It counts ticks of `clock_in` and produces either a toggled square wave (divide-by-2N) or a one-cycle pulse every N input cycles, with N and the mode reloadable at run time through a load/ack handshake. It replaces the fixed divide-by-5 stages between the 0.01 s base tick and the slower display and time-keeping domains.

## Interface
- `WIDTH`, 8: width of the counter and the divisor.
- `DEFAULT_DIV`, 5: divisor after reset, 1..2^WIDTH-1.
- `DEFAULT_MODE`, 0: mode after reset (0 = toggle, 1 = pulse).

- `clock_in` in 1: sole clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: count when high; hold everything when low.
- `div_value` in WIDTH: requested divisor N. A value of 0 is treated as 1.
- `div_mode` in 1: requested mode, bundled with `div_value`.
- `div_load` in 1: load request. Hold high with data stable until `div_ack`.
- `div_ack` out 1: one-cycle pulse in the cycle the new divisor becomes active.
- `clock_out` out 1: toggle mode: square wave with period 2N; pulse mode: equals `tick`.
- `tick` out 1: one-cycle pulse at each wrap.
- `timer_cnt` out WIDTH: current count, 0..N-1.

## Operation
- Active state: `act_div`, `act_mode`. Shadow state: `pend`, `pend_div`, `pend_mode`.
- Terminal condition: `timer_cnt >= act_div-1`. The `>=` keeps the block safe against an out-of-range count.
- **Enable high, not terminal:** `timer_cnt` increments; `tick` = 0; `clock_out` holds in toggle mode and is 0 in pulse mode.
- **Enable high, terminal:**
  - `timer_cnt` goes to 0 and `tick` = 1.
  - Toggle mode: `clock_out` inverts. Pulse mode: `clock_out` = 1.
  - If `pend` = 1: `act_div` and `act_mode` take the shadow values, `pend` clears, `div_ack` = 1. The new divisor governs the next period. `clock_out`/`tick` in this cycle follow the old mode.
- **Enable low:**
  - `timer_cnt` holds, `tick` = 0, `clock_out` holds.
  - If `pend` = 1: apply immediately, clear `timer_cnt` to 0, pulse `div_ack`. If the new mode is pulse, `clock_out` goes to 0.
- **Capture:** when `div_load` = 1, `pend` = 0 and `div_ack` = 0, latch `pend_div` (0 becomes 1) and `pend_mode`, and set `pend`.
  - Capture and apply never happen in the same cycle; apply happens at the earliest on the next edge.
  - While `pend` = 1, further `div_load` is ignored.
  - The requester drops `div_load` the cycle after `div_ack`. `div_load` still high in the ack cycle does not re-capture.
- **Divisor N = 1:** terminal every enabled cycle. `tick` is constantly 1; toggle mode gives `clock_in`/2.
- **Wrap-around:** the counter never exceeds N-1. The increment is WIDTH bits wide with no carry out.

## Timing
- **Reset values:**
  - Outputs: `timer_cnt`=0, `clock_out`=0, `tick`=0, `div_ack`=0.
  - Internal: `act_div`=DEFAULT_DIV, `act_mode`=DEFAULT_MODE, `pend`=0.
- **Reset priority:** reset overrides enable and load. Reset mid-period or with `pend` set discards the pending request; no ack is issued.
- **Edge sequence:** with enable high from the first edge after reset, `timer_cnt` runs 1,2,…,N-1,0,…
  - `tick` is high after edges N, 2N, 3N, …
  - In toggle mode `clock_out` changes at the same edges.
- **Load latency, enable high:** capture edge + 1 to N edges (the next terminal edge).
- **Load latency, enable low:** capture edge + 1 edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `clk_div_pkg`:
  - Mode constants `MODE_TOGGLE`=1'b0, `MODE_PULSE`=1'b1.
  - Default divisor/mode localparams shared by the timebase instances.
- One sub-module, `div_load_shadow`: capture register plus `pend` flag, with an `apply` input and an `ack` output. Counter and output logic stay in the top module.
- Target size: about 150–250 lines of RTL in total.

## Test plan
1. **Reset default:** reset 2 cycles, then enable=1 for 30 cycles → `tick` at edges 5,10,15,20,25,30; `clock_out` toggles at those edges (period 10); `timer_cnt` cycles 0..4.
2. **Runtime reload:**
   - Stimulus: at count 2, load `div_value`=3, mode 0.
   - Required: `div_ack` at the next wrap (2 edges later); following periods 3 cycles; `clock_out` period 6.
3. **Pulse mode with enable gaps:**
   - Stimulus: load `div_value`=4, mode 1, with enable low.
   - Required: ack 1 edge after capture; `timer_cnt`=0. With enable high, `clock_out`=`tick` is high once every 4 cycles. With enable low for 3 cycles mid-period, count and outputs hold and the period stretches by 3.
4. **Edge divisors:**
   - `div_value`=0 → acts as 1, `tick` high every enabled cycle, toggle output at `clock_in`/2.
   - `div_value`=255 with WIDTH=8 → `tick` every 255 cycles, no counter overflow.
5. **Handshake contention:**
   - Second `div_load` while `pend`=1 → ignored.
   - Reset asserted with `pend`=1 → no `div_ack`, divisor returns to 5.
   - `div_load` held through the ack cycle → no second capture.
